// File: rtl/seg_to_ram_writer.sv
// Decodes a stream of active-low 7-segment codes back to 5-bit symbols, buffers them
// and writes them into the read/write RAM at auto-incrementing addresses.
module seg_to_ram_writer #(
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W:0]   Count,
    input  logic [6:0]        Seg_In,
    input  logic              Seg_Valid,
    output logic              Seg_Ready,
    input  logic              Wr_Hold,
    output logic              WE_Out,
    output logic [ADDR_W-1:0] Addr_Out,
    output logic [4:0]        Data_Out,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W-1:0] Err_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   ACC_ONE   = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE   = 1;
    localparam logic [ADDR_W-1:0] ERR_MAX   = '1;
    localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
    localparam logic [PTR_W:0]    FILL_ONE  = 1;
    localparam logic [PTR_W:0]    FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [4:0]        SYM_BAD   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    // Transfer context latched on an accepted Start
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   accepted_reg;
    logic [ADDR_W-1:0] wr_idx_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] err_count_reg;

    // Symbol buffer: array storage with registered read into the write port
    logic [4:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    fill_reg;
    logic              fifo_full;
    logic              fifo_empty;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [4:0]        data_reg;

    logic [4:0]        sym;
    logic              sym_bad;
    logic              start_go;
    logic [ADDR_W:0]   count_clamped;
    logic              push;
    logic              pop;
    logic              last_accept;

    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] s;
        case (code)
            7'h40:   s = 5'd0;
            7'h79:   s = 5'd1;
            7'h24:   s = 5'd2;
            7'h30:   s = 5'd3;
            7'h19:   s = 5'd4;
            7'h12:   s = 5'd5;
            7'h02:   s = 5'd6;
            7'h78:   s = 5'd7;
            7'h00:   s = 5'd8;
            7'h10:   s = 5'd9;
            7'h08:   s = 5'd10;
            7'h03:   s = 5'd11;
            7'h46:   s = 5'd12;
            7'h21:   s = 5'd13;
            7'h06:   s = 5'd14;
            7'h0E:   s = 5'd15;
            7'h7F:   s = 5'd16;
            default: s = SYM_BAD;
        endcase
        return s;
    endfunction

    assign sym     = seg_decode(Seg_In);
    assign sym_bad = (sym == SYM_BAD);

    assign fifo_full  = (fill_reg == FILL_FULL);
    assign fifo_empty = (fill_reg == '0);

    assign count_clamped = (Count > MAX_COUNT) ? MAX_COUNT : Count;
    assign start_go      = (state_reg == ST_IDLE) && Start && (Count != '0);

    // Seg_Ready already excludes a full buffer, so push never overflows
    assign push        = Seg_Valid && Seg_Ready;
    assign pop         = !fifo_empty && !Wr_Hold;
    assign last_accept = push && ((accepted_reg + ACC_ONE) == count_reg);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    state_next = (Count == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (last_accept) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Empty here means the final pop already launched its write
                if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        Seg_Ready = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state_reg)
            ST_CAPTURE: begin
                Busy      = 1'b1;
                Seg_Ready = !fifo_full && (accepted_reg < count_reg);
            end
            ST_DRAIN: begin
                Busy = 1'b1;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            base_reg      <= '0;
            count_reg     <= '0;
            accepted_reg  <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else if (start_go) begin
            base_reg      <= Base_Addr;
            count_reg     <= count_clamped;
            accepted_reg  <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else if (push) begin
            accepted_reg <= accepted_reg + ACC_ONE;
            if (sym_bad) begin
                err_reg <= 1'b1;
                if (err_count_reg != ERR_MAX) begin
                    err_count_reg <= err_count_reg + IDX_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sym;
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + FILL_ONE;
                2'b01:   fill_reg <= fill_reg - FILL_ONE;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Address and data hold their last values between write strobes
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
            wr_idx_reg <= '0;
        end else begin
            we_reg <= pop;
            if (start_go) begin
                wr_idx_reg <= '0;
            end else if (pop) begin
                wr_idx_reg <= wr_idx_reg + IDX_ONE;
            end
            if (pop) begin
                addr_reg <= base_reg + wr_idx_reg;
                data_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    assign WE_Out    = we_reg;
    assign Addr_Out  = addr_reg;
    assign Data_Out  = data_reg;
    assign Err       = err_reg;
    assign Err_Count = err_count_reg;

endmodule

// File: tb/tb_seg_to_ram_writer.sv
// Randomised bench for seg_to_ram_writer: a table-driven reference model predicts the
// RAM write list and error status of every transfer.
module tb_seg_to_ram_writer;

    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int SPACE      = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W-1:0] Base_Addr;
    logic [ADDR_W:0]   Count;
    logic [6:0]        Seg_In;
    logic              Seg_Valid;
    logic              Seg_Ready;
    logic              Wr_Hold;
    logic              WE_Out;
    logic [ADDR_W-1:0] Addr_Out;
    logic [4:0]        Data_Out;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [ADDR_W-1:0] Err_Count;

    seg_to_ram_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock     (clock),
        .Reset     (Reset),
        .Start     (Start),
        .Base_Addr (Base_Addr),
        .Count     (Count),
        .Seg_In    (Seg_In),
        .Seg_Valid (Seg_Valid),
        .Seg_Ready (Seg_Ready),
        .Wr_Hold   (Wr_Hold),
        .WE_Out    (WE_Out),
        .Addr_Out  (Addr_Out),
        .Data_Out  (Data_Out),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Err_Count (Err_Count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t mon_w;
    wr_t wr_q[$];
    int  done_cnt = 0;
    int  done_cyc = -1;

    always @(negedge clock) begin
        if (WE_Out === 1'b1) begin
            mon_w.addr = int'(Addr_Out);
            mon_w.data = int'(Data_Out);
            mon_w.cyc  = cyc;
            wr_q.push_back(mon_w);
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: symbol s is displayed by seg_codes[s]; 7F is blank (16)
    logic [6:0] seg_codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] codes_q[$];
    int exp_addr[$];
    int exp_data[$];
    int acc_cyc[$];
    int m_err = 0;
    int m_err_cnt = 0;
    int start_cyc, busy_at_start, acc_at_release, ready_at_release, wr_at_release;

    function automatic int ref_symbol(input logic [6:0] code);
        if (code == 7'h7F) return 16;
        for (int s = 0; s < 16; s++) begin
            if (seg_codes[s] == code) return s;
        end
        return 31;
    endfunction

    function automatic logic [6:0] rand_code(input int bad_pct);
        logic [6:0] c;
        int k;
        if ($urandom_range(99) < bad_pct) begin
            c = 7'($urandom);
            while (ref_symbol(c) != 31) c = 7'($urandom);
        end else begin
            k = $urandom_range(16);
            c = (k == 16) ? 7'h7F : seg_codes[k];
        end
        return c;
    endfunction

    task automatic fill_codes(input int n, input int bad_pct);
        codes_q.delete();
        for (int i = 0; i < n; i++) codes_q.push_back(rand_code(bad_pct));
    endtask

    task automatic build_model(input int base, input int cnt);
        int n, s;
        n = (cnt > SPACE) ? SPACE : cnt;
        exp_addr.delete();
        exp_data.delete();
        if (cnt > 0) begin
            m_err = 0;
            m_err_cnt = 0;
        end
        for (int i = 0; i < n; i++) begin
            s = ref_symbol(codes_q[i]);
            exp_addr.push_back((base + i) % SPACE);
            exp_data.push_back(s);
            if (s == 31) begin
                m_err = 1;
                if (m_err_cnt < SPACE - 1) m_err_cnt++;
            end
        end
    endtask

    // Drives one whole transfer; hold_first forces Wr_Hold for the first cycles
    task automatic run_transfer(input int base, input int cnt, input int hold_pct,
                                input int valid_pct, input int hold_first, input bit stray);
        int n, idx, guard;
        bit take;
        n = (cnt > SPACE) ? SPACE : cnt;
        build_model(base, cnt);
        wr_q.delete();
        acc_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        acc_at_release = -1;
        ready_at_release = -1;
        wr_at_release = -1;
        Base_Addr = ADDR_W'(base);
        Count = (ADDR_W+1)'(cnt);
        Start = 1'b1;
        @(posedge clock); #1;
        Start = 1'b0;
        start_cyc = cyc;
        busy_at_start = int'(Busy);
        idx = 0;
        guard = 0;
        while (idx < n && guard < 3000) begin
            Seg_In = codes_q[idx];
            Seg_Valid = ($urandom_range(99) < valid_pct);
            Wr_Hold = (guard < hold_first) ? 1'b1 : ($urandom_range(99) < hold_pct);
            if (stray && guard == 1) begin
                Start = 1'b1;
                Base_Addr = ADDR_W'($urandom);
                Count = (ADDR_W+1)'($urandom_range(40));
            end else begin
                Start = 1'b0;
            end
            @(negedge clock);
            take = Seg_Valid && Seg_Ready;
            @(posedge clock); #1;
            if (take) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            guard++;
            if (hold_first > 0 && guard == hold_first) begin
                acc_at_release = idx;
                ready_at_release = int'(Seg_Ready);
                wr_at_release = wr_q.size();
            end
        end
        Start = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: accepted %0d of %0d codes", idx, n);
        end
        // Keep offering codes while draining: nothing more may be consumed
        Seg_Valid = 1'b1;
        Seg_In = rand_code(0);
        guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            Wr_Hold = ($urandom_range(99) < hold_pct);
            @(posedge clock); #1;
            guard++;
        end
        Seg_Valid = 1'b0;
        Wr_Hold = 1'b0;
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no Done within %0d cycles", guard);
        end
        repeat (3) @(posedge clock);
        #1;
        $display("xfer base=%0d count=%0d accepted=%0d writes=%0d err=%0b err_count=%0d done=%0d",
                 base, cnt, idx, wr_q.size(), Err, Err_Count, done_cnt);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Seg_Valid = 1'b0;
        Wr_Hold = 1'b0;
        Base_Addr = '0;
        Count = '0;
        Seg_In = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({WE_Out, Busy, Done, Err, Seg_Ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got we,busy,done,err,ready=%b expected 00000",
                     {WE_Out, Busy, Done, Err, Seg_Ready});
        end
        checks++;
        if (Addr_Out !== '0 || Data_Out !== '0 || Err_Count !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%0d data=%0d err_count=%0d expected 0,0,0",
                     Addr_Out, Data_Out, Err_Count);
        end
        Reset = 1'b0;
        Seg_Valid = 1'b1;
        Seg_In = 7'h40;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (Seg_Ready !== 1'b0 || Busy !== 1'b0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL idle_ignores_valid: got ready=%b busy=%b writes=%0d expected 0,0,0",
                     Seg_Ready, Busy, wr_q.size());
        end
        Seg_Valid = 1'b0;
    endtask

    task automatic test_normal();
        codes_q = '{7'h40, 7'h79, 7'h24, 7'h40};
        run_transfer(0, 3, 0, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL normal_count: got %0d writes expected %0d", wr_q.size(), exp_addr.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                errors++;
                $display("FAIL normal_write%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (busy_at_start != 1) begin
            errors++;
            $display("FAIL normal_busy: got %0d expected 1", busy_at_start);
        end
        checks++;
        if (wr_q.size() == 0 || wr_q[0].cyc != acc_cyc[0] + 1) begin
            errors++;
            $display("FAIL normal_latency: first write not one cycle after first accept (accept cyc %0d)",
                     acc_cyc[0]);
        end
        checks++;
        if (acc_cyc.size() != 3 || acc_cyc[2] != acc_cyc[0] + 2 ||
            wr_q.size() != 3 || wr_q[2].cyc != wr_q[0].cyc + 2) begin
            errors++;
            $display("FAIL normal_throughput: got %0d accepts %0d writes, not back to back expected 3 each",
                     acc_cyc.size(), wr_q.size());
        end
        checks++;
        if (wr_q.size() == 0 || done_cyc != wr_q[wr_q.size()-1].cyc + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL normal_done: got done_cnt=%0d done_cyc=%0d expected 1 pulse after last write",
                     done_cnt, done_cyc);
        end
        checks++;
        if (Err !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_status: got err=%b busy=%b expected 0,0", Err, Busy);
        end
    endtask

    task automatic test_wrap_blank();
        codes_q = '{7'h7F, 7'h0E, 7'h40};
        run_transfer(31, 2, 0, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes expected 2", wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                errors++;
                $display("FAIL wrap_write%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_codes(9, 0);
        run_transfer(12, 8, 0, 100, 10, 1'b0);
        checks++;
        if (acc_at_release != FIFO_DEPTH || ready_at_release != 0 || wr_at_release != 0) begin
            errors++;
            $display("FAIL backpressure_stall: got accepts=%0d ready=%0d writes=%0d expected %0d,0,0",
                     acc_at_release, ready_at_release, wr_at_release, FIFO_DEPTH);
        end
        checks++;
        if (wr_q.size() != exp_addr.size() || done_cnt != 1) begin
            errors++;
            $display("FAIL backpressure_count: got %0d writes done=%0d expected %0d writes done=1",
                     wr_q.size(), done_cnt, exp_addr.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                errors++;
                $display("FAIL backpressure_write%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_bad_code();
        codes_q = '{7'h55, 7'h12, 7'h40};
        run_transfer(5, 2, 0, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != 2 || wr_q[0].data != 31 || wr_q[1].data != 5) begin
            errors++;
            $display("FAIL bad_writes: got %0d writes first data %0d expected 2 writes data 31,5",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].data : -1);
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (Err !== 1'b1 || int'(Err_Count) != m_err_cnt || m_err_cnt != 1) begin
            errors++;
            $display("FAIL bad_err_held: got err=%b err_count=%0d expected 1,%0d", Err, Err_Count, m_err_cnt);
        end
        fill_codes(5, 0);
        run_transfer(20, 4, 10, 100, 0, 1'b0);
        checks++;
        if (Err !== 1'b0 || Err_Count !== '0) begin
            errors++;
            $display("FAIL bad_err_cleared: got err=%b err_count=%0d expected 0,0", Err, Err_Count);
        end
    endtask

    task automatic test_degenerate();
        fill_codes(2, 0);
        run_transfer(7, 0, 0, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != 0 || done_cnt != 1 || done_cyc != start_cyc || busy_at_start != 0) begin
            errors++;
            $display("FAIL count0: got writes=%0d done=%0d done_cyc=%0d busy=%0d expected 0,1,%0d,0",
                     wr_q.size(), done_cnt, done_cyc, busy_at_start, start_cyc);
        end
        fill_codes(41, 0);
        run_transfer(3, 40, 20, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != SPACE || done_cnt != 1) begin
            errors++;
            $display("FAIL count40: got %0d writes done=%0d expected %0d writes done=1",
                     wr_q.size(), done_cnt, SPACE);
        end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                errors++;
                $display("FAIL count40_write%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_err_saturate();
        fill_codes(33, 100);
        run_transfer(0, 32, 0, 100, 0, 1'b0);
        checks++;
        if (Err !== 1'b1 || int'(Err_Count) != m_err_cnt || wr_q.size() != SPACE) begin
            errors++;
            $display("FAIL err_saturate: got err=%b err_count=%0d writes=%0d expected 1,%0d,%0d",
                     Err, Err_Count, wr_q.size(), m_err_cnt, SPACE);
        end
    endtask

    task automatic test_reset_mid();
        int idx, guard;
        bit take;
        fill_codes(9, 0);
        Base_Addr = 5'd9;
        Count = 6'd8;
        Start = 1'b1;
        @(posedge clock); #1;
        Start = 1'b0;
        Wr_Hold = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 2 && guard < 50) begin
            Seg_In = codes_q[idx];
            Seg_Valid = 1'b1;
            @(negedge clock);
            take = Seg_Valid && Seg_Ready;
            @(posedge clock); #1;
            if (take) idx++;
            guard++;
        end
        Seg_Valid = 1'b0;
        @(posedge clock);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({WE_Out, Busy, Done, Err, Seg_Ready} !== 5'b0 || Addr_Out !== '0 ||
            Data_Out !== '0 || Err_Count !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got we=%b busy=%b addr=%0d data=%0d expected all 0",
                     WE_Out, Busy, Addr_Out, Data_Out);
        end
        m_err = 0;
        m_err_cnt = 0;
        wr_q.delete();
        done_cnt = 0;
        Seg_Valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        Reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        Seg_Valid = 1'b0;
        checks++;
        if (wr_q.size() != 0 || done_cnt != 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got writes=%0d done=%0d busy=%b expected 0,0,0",
                     wr_q.size(), done_cnt, Busy);
        end
        fill_codes(6, 0);
        run_transfer(29, 5, 0, 100, 0, 1'b0);
        checks++;
        if (wr_q.size() != exp_addr.size() || done_cnt != 1) begin
            errors++;
            $display("FAIL reset_mid_restart: got %0d writes done=%0d expected %0d done=1",
                     wr_q.size(), done_cnt, exp_addr.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                errors++;
                $display("FAIL reset_mid_write%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                         wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random();
        int base, cnt;
        for (int t = 0; t < 20; t++) begin
            base = $urandom_range(SPACE - 1);
            cnt = $urandom_range(40);
            fill_codes(41, 10);
            run_transfer(base, cnt, 30, 70, 0, 1'b1);
            checks++;
            if (wr_q.size() != exp_addr.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL random%0d_count: got %0d writes done=%0d expected %0d done=1",
                         t, wr_q.size(), done_cnt, exp_addr.size());
            end
            for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (wr_q[i].addr != exp_addr[i] || wr_q[i].data != exp_data[i]) begin
                    errors++;
                    $display("FAIL random%0d_write%0d: got (%0d,%0d) expected (%0d,%0d)", t, i,
                             wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (int'(Err) != m_err || int'(Err_Count) != m_err_cnt) begin
                errors++;
                $display("FAIL random%0d_err: got err=%b err_count=%0d expected %0d,%0d",
                         t, Err, Err_Count, m_err, m_err_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wrap_blank();
        test_backpressure();
        test_bad_code();
        test_degenerate();
        test_err_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_to_ram_writer.md
Name: seg_to_ram_writer

Overview:
- Reverse path of the display chain: accepts a stream of 7-segment codes and decodes each back to a 5-bit symbol.
- Buffers the symbols and writes them into the Read_Write RAM at auto-incrementing addresses.
- Lets captured or externally supplied display patterns reload RAM contents, which the existing counter/ROM/shift-register path then replays.

Parameters:
- ADDR_W, 5, RAM address width; address space is 2^ADDR_W.
- FIFO_DEPTH, 4, decoded-symbol buffer entries; power of two, minimum 2.

Ports:
- clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  one-cycle pulse that begins a transfer.
- Base_Addr  input  ADDR_W  first RAM address written.
- Count  input  ADDR_W+1  number of codes to capture; 0..32.
- Seg_In  input  7  segment code, active-low, bit6=g .. bit0=a.
- Seg_Valid  input  1  Seg_In holds a code.
- Seg_Ready  output  1  block accepts Seg_In this cycle.
- Wr_Hold  input  1  RAM port busy; stall writes.
- WE_Out  output  1  RAM write enable, connects to RAM WE.
- Addr_Out  output  ADDR_W  RAM address, connects to address_RW.
- Data_Out  output  5  RAM data, connects to data_in_RW.
- Busy  output  1  transfer in progress.
- Done  output  1  one-cycle pulse when the transfer completes.
- Err  output  1  sticky: at least one unrecognised code in the current transfer.
- Err_Count  output  ADDR_W  number of unrecognised codes, saturating at 31.

Behaviour:
- Reset (asynchronous) values:
  - All outputs 0.
  - FIFO empty; state IDLE.
  - A reset mid-transfer aborts it with no further writes and no Done pulse.
- Decode table (Seg_In hex -> symbol), combinational:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - 7F (blank) -> 16
  - Any other code -> 31; increments Err_Count (saturating) and sets Err.
- State machine: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE:
    - Start with Count=0 -> DONE; no writes.
    - Start with Count>0 -> CAPTURE; latch Base_Addr; latch Count clamped to 32; clear accepted counter, Err and Err_Count.
    - Start while not in IDLE is ignored.
  - CAPTURE:
    - Seg_Ready = (FIFO not full) AND (accepted < Count).
    - Handshake occurs when Seg_Valid AND Seg_Ready: the decoded symbol is pushed the same cycle and accepted increments.
    - Go to DRAIN on the cycle the last code is accepted.
  - DRAIN:
    - Seg_Ready = 0.
    - Go to DONE when the FIFO is empty and the final write has been issued.
  - DONE:
    - Done=1 for exactly one cycle, then IDLE.
- Busy = 1 in CAPTURE and DRAIN only.
- Write side:
  - Each cycle with the FIFO non-empty and Wr_Hold=0: pop one entry; next cycle drive WE_Out=1, Addr_Out = latched base + write index (mod 2^ADDR_W), Data_Out = symbol.
  - Outputs are registered; otherwise WE_Out=0, and Addr_Out/Data_Out hold their last values.
  - Latency: code accepted at edge N appears with WE_Out=1 after edge N+1 when the FIFO was empty and Wr_Hold=0.
  - Sustained throughput: 1 code per cycle.
- Boundary conditions:
  - Address wrap-around: Base_Addr=30, Count=4 writes addresses 30, 31, 0, 1.
  - Simultaneous push and pop on a full FIFO: no push occurs, because Seg_Ready was already 0 at full.
  - Simultaneous push and pop otherwise: occupancy unchanged.
  - Wr_Hold asserted mid-stream: writes stall and the FIFO fills; Seg_Ready drops at full and resumes once a pop frees an entry.
  - Seg_Valid outside CAPTURE is ignored and consumes nothing.
  - Write order matches accept order; no writes are dropped or duplicated.

Test Plan:
- Normal transfer: Start, Base_Addr=0, Count=3, stream 40, 79, 24 with Seg_Valid held -> WE_Out pulses at addresses 0, 1, 2 with data 0, 1, 2; Done pulses one cycle after the last write; Err=0.
- Wrap and blank: Base_Addr=31, Count=2, codes 7F, 0E -> writes (31, 16) then (0, 15).
- Backpressure: Count=8, Wr_Hold=1 for 10 cycles -> Seg_Ready drops after 4 accepts; after release, 8 writes follow in order and Done fires.
- Bad code: Count=2, codes 55, 12 -> writes 31 then 5; Err=1, Err_Count=1, Err held until the next Start.
- Degenerate requests: Count=0 -> Done the cycle after the IDLE->DONE transition, no WE_Out; Count=40 -> exactly 32 writes.
- Reset mid-operation: Reset asserted during CAPTURE after 2 accepts -> all outputs 0 immediately, no further WE_Out; a new Start works normally.
